// File: rtl/seq_divider.sv
// Sequential signed restoring divider. Divides operand magnitudes one quotient
// bit per clock, then restores the signs in a single fix-up cycle.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_dvs;      // |divisor|
  logic [WIDTH-1:0] r_dq;       // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] r_rem;      // partial remainder
  logic             r_neg_dvd;
  logic             r_neg_dvs;
  logic             r_dz;

  logic [WIDTH-1:0] w_abs_dvd;
  logic [WIDTH-1:0] w_abs_dvs;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_fits;

  // Negating the most-negative value yields itself, which read as unsigned is
  // exactly its magnitude 2^(WIDTH-1), so no extra bit is needed here.
  assign w_abs_dvd = dividend[WIDTH-1] ? -dividend : dividend;
  assign w_abs_dvs = divisor[WIDTH-1]  ? -divisor  : divisor;

  // The remainder stays below |divisor| <= 2^(WIDTH-1), so one extra bit covers
  // the shifted value and the sign of the trial subtraction.
  assign w_shift = {r_rem, r_dq[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, r_dvs};
  assign w_fits  = ~w_trial[WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_dvs       <= '0;
      r_dq        <= '0;
      r_rem       <= '0;
      r_neg_dvd   <= 1'b0;
      r_neg_dvs   <= 1'b0;
      r_dz        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // state as it was before this edge regardless of statement order.
      done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_neg_dvd   <= dividend[WIDTH-1];
            r_neg_dvs   <= divisor[WIDTH-1];
            r_dvs       <= w_abs_dvs;
            r_cnt       <= CW'(WIDTH - 1);
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            if (divisor == '0) begin
              r_dz    <= 1'b1;
              r_dq    <= '1;
              r_rem   <= dividend;
              r_state <= S_DONE;
            end else begin
              r_dz    <= 1'b0;
              r_dq    <= w_abs_dvd;
              r_rem   <= '0;
              r_state <= S_CALC;
            end
          end
        end

        S_CALC: begin
          r_rem <= w_fits ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
          r_dq  <= {r_dq[WIDTH-2:0], w_fits};
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == '0) r_state <= S_FIX;
        end

        S_FIX: begin
          r_dq    <= (r_neg_dvd ^ r_neg_dvs) ? -r_dq : r_dq;
          r_rem   <= r_neg_dvd ? -r_rem : r_rem;
          busy    <= 1'b0;
          r_state <= S_DONE;
        end

        S_DONE: begin
          // A divide-by-zero arrives here still busy; drop busy for one cycle
          // first so both paths present the same busy/done shape.
          if (busy) begin
            busy <= 1'b0;
          end else begin
            done        <= 1'b1;
            quotient    <= r_dq;
            remainder   <= r_rem;
            div_by_zero <= r_dz;
            r_state     <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corner cases, protocol checks,
// mid-operation reset, and a scoreboard-driven random sweep.
module tb_seq_divider;

  localparam int W = 32;
  localparam logic [W-1:0] MIN_NEG = 32'h8000_0000;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t mk(input logic [W-1:0] q, input logic [W-1:0] r, input logic dz);
    exp_t e;
    e.q  = q;
    e.r  = r;
    e.dz = dz;
    return e;
  endfunction

  // Reference model built on the language's signed / and %.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sd;
    exp_t e;
    sa = a;
    sd = b;
    if (b == '0)                         e = mk('1, a, 1'b1);
    else if (a == MIN_NEG && b == '1)    e = mk(MIN_NEG, '0, 1'b0);
    else                                 e = mk(sa / sd, sa % sd, 1'b0);
    return e;
  endfunction

  function automatic logic [W-1:0] mag(input logic [W-1:0] x);
    return x[W-1] ? -x : x;
  endfunction

  // Called #1 after an edge; returns #1 after the accepting edge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
    sb.push_back(e);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int busy_cyc, output bit ok);
    lat      = 0;
    busy_cyc = 0;
    ok       = 1'b0;
    for (int i = 0; i < W + 20; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy) busy_cyc++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    #2;
    n_tests++;
    if ({busy, done, div_by_zero} !== 3'b000)
      begin n_fail++; $display("FAIL reset_flags: got %b want 000", {busy, done, div_by_zero}); end
    n_tests++;
    if (quotient !== '0 || remainder !== '0)
      begin n_fail++; $display("FAIL reset_data: got q=%h r=%h want 0/0", quotient, remainder); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_basic;
    logic [W-1:0] a_tab [4];
    logic [W-1:0] b_tab [4];
    logic [W-1:0] q_tab [4];
    logic [W-1:0] r_tab [4];
    int   lat;
    int   bc;
    bit   ok;
    exp_t e;
    a_tab = '{-49896, -49896, 7, -7};
    b_tab = '{616, -81, -2, 2};
    q_tab = '{-81, 616, -3, -3};
    r_tab = '{0, 0, 1, -1};
    for (int i = 0; i < 4; i++) begin
      launch(a_tab[i], b_tab[i], mk(q_tab[i], r_tab[i], 1'b0));
      wait_done(lat, bc, ok);
      e = sb.pop_front();
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL basic%0d_timeout: no done within %0d cycles", i, W + 20); end
      if (i == 0) begin
        n_tests++;
        if (lat != W + 2) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", lat, W + 2); end
        n_tests++;
        if (bc != W + 1) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want %0d", bc, W + 1); end
      end
      n_tests++;
      if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz)
        begin
          n_fail++;
          $display("FAIL basic%0d_result: got q=%0d r=%0d dz=%b want q=%0d r=%0d dz=%b", i,
                   $signed(quotient), $signed(remainder), div_by_zero, $signed(e.q), $signed(e.r), e.dz);
        end
      @(posedge clk);
      #1;
      n_tests++;
      if (done !== 1'b0 || busy !== 1'b0)
        begin n_fail++; $display("FAIL basic%0d_done_pulse: got done=%b busy=%b want 0/0", i, done, busy); end
    end
  endtask

  task automatic test_div_zero;
    int   lat;
    int   bc;
    bit   ok;
    exp_t e;
    launch(1234, 0, mk(32'hFFFF_FFFF, 1234, 1'b1));
    wait_done(lat, bc, ok);
    e = sb.pop_front();
    n_tests++;
    if (!ok || lat != 2) begin n_fail++; $display("FAIL div0_latency: got %0d (ok=%b) want 2", lat, ok); end
    n_tests++;
    if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz)
      begin
        n_fail++;
        $display("FAIL div0_result: got q=%h r=%0d dz=%b want q=%h r=%0d dz=%b",
                 quotient, remainder, div_by_zero, e.q, e.r, e.dz);
      end
    @(posedge clk);
    #1;
    n_tests++;
    if (div_by_zero !== 1'b1) begin n_fail++; $display("FAIL div0_hold: got %b want 1", div_by_zero); end
    launch(40, 8, mk(5, 0, 1'b0));
    n_tests++;
    if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL div0_clear_on_start: got %b want 0", div_by_zero); end
    wait_done(lat, bc, ok);
    e = sb.pop_front();
    n_tests++;
    if (!ok || quotient !== e.q || remainder !== e.r)
      begin n_fail++; $display("FAIL after_div0: got q=%0d r=%0d want q=%0d r=%0d", quotient, remainder, e.q, e.r); end
  endtask

  task automatic test_min_neg;
    int   lat;
    int   bc;
    bit   ok;
    exp_t e;
    logic [W-1:0] b_tab [2];
    b_tab = '{32'hFFFF_FFFF, 32'h0000_0001};
    for (int i = 0; i < 2; i++) begin
      launch(MIN_NEG, b_tab[i], mk(MIN_NEG, '0, 1'b0));
      wait_done(lat, bc, ok);
      e = sb.pop_front();
      n_tests++;
      if (!ok || quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz)
        begin
          n_fail++;
          $display("FAIL min_neg%0d: got q=%h r=%h dz=%b want q=%h r=%h dz=%b (ok=%b)", i,
                   quotient, remainder, div_by_zero, e.q, e.r, e.dz, ok);
        end
    end
  endtask

  task automatic test_protocol;
    int   lat;
    int   bc;
    bit   ok;
    exp_t e;
    launch(1000, 3, mk(333, 1, 1'b0));
    repeat (5) @(posedge clk);
    #1;
    dividend = 77;
    divisor  = 7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 55;
    divisor  = 5;
    wait_done(lat, bc, ok);
    e = sb.pop_front();
    n_tests++;
    if (!ok || quotient !== e.q || remainder !== e.r)
      begin n_fail++; $display("FAIL ignore_start: got q=%0d r=%0d want q=%0d r=%0d (ok=%b)", quotient, remainder, e.q, e.r, ok); end
    @(posedge clk);
    #1;
    launch(-200, 7, mk(-28, -4, 1'b0));
    wait_done(lat, bc, ok);
    e = sb.pop_front();
    n_tests++;
    if (!ok || lat != W + 2) begin n_fail++; $display("FAIL back_to_back_latency: got %0d want %0d", lat, W + 2); end
    n_tests++;
    if (quotient !== e.q || remainder !== e.r)
      begin
        n_fail++;
        $display("FAIL back_to_back_result: got q=%0d r=%0d want q=%0d r=%0d",
                 $signed(quotient), $signed(remainder), $signed(e.q), $signed(e.r));
      end
  endtask

  task automatic test_reset_mid;
    int   lat;
    int   bc;
    bit   ok;
    exp_t e;
    launch(5000, 3, mk(1666, 2, 1'b0));
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({busy, done, div_by_zero} !== 3'b000 || quotient !== '0 || remainder !== '0)
      begin
        n_fail++;
        $display("FAIL reset_mid: got busy=%b done=%b dz=%b q=%h r=%h want all 0",
                 busy, done, div_by_zero, quotient, remainder);
      end
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    launch(100, 7, mk(14, 2, 1'b0));
    wait_done(lat, bc, ok);
    e = sb.pop_front();
    n_tests++;
    if (!ok || lat != W + 2 || quotient !== e.q || remainder !== e.r)
      begin n_fail++; $display("FAIL after_reset: got q=%0d r=%0d lat=%0d want q=%0d r=%0d lat=%0d", quotient, remainder, lat, e.q, e.r, W + 2); end
  endtask

  task automatic test_random;
    int           lat;
    int           bc;
    bit           ok;
    exp_t         e;
    logic [W-1:0] a;
    logic [W-1:0] b;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      if ($urandom_range(0, 15) == 0) a = MIN_NEG;
      case ($urandom_range(0, 4))
        0: b = $urandom;
        1: b = $urandom_range(1, 100);
        2: b = $urandom >> $urandom_range(1, 30);
        3: case ($urandom_range(0, 3))
             0:       b = '0;
             1:       b = 32'h0000_0001;
             2:       b = '1;
             default: b = MIN_NEG;
           endcase
        default: b = $urandom >> 16;
      endcase
      if ($urandom_range(0, 1) == 1 && b != MIN_NEG) b = -b;
      launch(a, b, model(a, b));
      wait_done(lat, bc, ok);
      e = sb.pop_front();
      n_tests++;
      if (!ok || quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz)
        begin
          n_fail++;
          $display("FAIL rand%0d %h/%h: got q=%h r=%h dz=%b want q=%h r=%h dz=%b (ok=%b)", i, a, b,
                   quotient, remainder, div_by_zero, e.q, e.r, e.dz, ok);
        end
      if (b != '0) begin
        n_tests++;
        if (quotient * b + remainder !== a || !(mag(remainder) < mag(b)))
          begin n_fail++; $display("FAIL rand%0d_invariant %h/%h: got q=%h r=%h", i, a, b, quotient, remainder); end
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    test_reset;
    test_basic;
    test_div_zero;
    test_min_neg;
    test_protocol;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
